sound_ch1_control: RTL and testbench
====================================

SOUND_CH1_CONTROL -- requirements
Module: sound_ch1_control

Interface
REQ-001 SHALL have ports, clock and reset first: I_BITCLK in 1, sole clock, all state on rising edge; I_RESET_N in 1, reset, asynchronous and active-low.
REQ-002 SHALL have I_FRAME_TICK in 1: one-cycle strobe, 512 Hz frame-sequencer step.
REQ-003 SHALL have I_TRIGGER in 1: one-cycle channel (re)start strobe.
REQ-004 SHALL have I_FREQ_WR in 1 (strobe) and I_FREQUENCY in 11 (raw period code).
REQ-005 SHALL have I_LENGTH_WR in 1 (strobe), I_LENGTH_DATA in 6, I_LENGTH_EN in 1.
REQ-006 SHALL have I_SWEEP_PERIOD in 3, I_SWEEP_NEGATE in 1, I_SWEEP_SHIFT in 3.
REQ-007 SHALL have I_ENV_INIT in 4, I_ENV_UP in 1, I_ENV_PERIOD in 3, I_DUTY in 2.
REQ-008 SHALL have outputs O_FREQUENCY 11, O_DUTY_CYCLE 2, O_VOLUME 4, O_WAVEFORM_EN 1; all registered, driving the square-wave generator's I_FREQUENCY / I_DUTY_CYCLE / I_VOLUME / I_WAVEFORM_EN.

Function
REQ-009 SHALL keep a 3-bit step counter, +1 mod 8 per I_FRAME_TICK, evaluated with the pre-increment value; length clocks on steps 0,2,4,6; sweep clocks on steps 2,6; envelope clocks on step 7.
REQ-010 SHALL drive O_DUTY_CYCLE = I_DUTY registered, one cycle latency.
REQ-011 SHALL set dac_on = (I_ENV_INIT != 0) | I_ENV_UP; when dac_on = 0, channel_on SHALL clear next cycle.
REQ-012 SHALL drive O_WAVEFORM_EN = channel_on.
REQ-013 Length: 7-bit counter range 0..64; I_LENGTH_WR loads 64 - I_LENGTH_DATA; on length clock with I_LENGTH_EN = 1 and counter > 0, decrement; transition to 0 clears channel_on.
REQ-014 Frequency: I_FREQ_WR loads O_FREQUENCY from I_FREQUENCY; shadow unchanged.
REQ-015 Sweep timer: 3-bit, period 0 treated as 8; on sweep clock, decrement; on reaching 0, reload, then if sweep_en and I_SWEEP_PERIOD != 0 perform a sweep calculation.
REQ-016 Sweep calculation: 12-bit new = shadow +/- (shadow >> I_SWEEP_SHIFT), minus when I_SWEEP_NEGATE; new > 2047 clears channel_on; else if I_SWEEP_SHIFT != 0, shadow and O_FREQUENCY take new[10:0].
REQ-017 Envelope: 3-bit timer; on envelope clock with I_ENV_PERIOD != 0, decrement; on reaching 0, reload with I_ENV_PERIOD and step O_VOLUME +1 if I_ENV_UP and < 15, -1 if down and > 0, else hold (saturate, never wrap); I_ENV_PERIOD = 0 freezes volume.
REQ-018 Trigger, all in one cycle: channel_on = dac_on; length 0 -> 64 (else kept); shadow and O_FREQUENCY = I_FREQUENCY; sweep timer reload; sweep_en = (period != 0) | (shift != 0); if shift != 0, immediate overflow check per REQ-016 without writeback; O_VOLUME = I_ENV_INIT; envelope timer = I_ENV_PERIOD.
REQ-019 Trigger with I_FRAME_TICK same cycle: step counter SHALL still advance; that tick's length/sweep/envelope actions SHALL be discarded.
REQ-020 I_LENGTH_WR with I_TRIGGER same cycle: the write SHALL apply first, then the REQ-018 zero-to-64 rule.
REQ-021 I_FREQ_WR with sweep writeback same cycle: sweep writeback SHALL win O_FREQUENCY.
REQ-022 While channel_on = 0, length SHALL still count; sweep and envelope SHALL hold.

Reset
REQ-023 I_RESET_N low SHALL immediately clear step counter, length, timers, shadow, sweep_en, channel_on, O_FREQUENCY, O_DUTY_CYCLE, O_VOLUME and O_WAVEFORM_EN to 0.
REQ-024 Reset deasserted mid-operation SHALL require a new I_TRIGGER before O_WAVEFORM_EN = 1; deassertion SHALL be synchronised so the first post-reset edge sees clean state.

Verification
REQ-025 INIT=10, UP=0, PERIOD=1, trigger, 24 ticks -> O_VOLUME 10,9,8 after steps 7 of frames 1..3; later stays 0, never wraps to 15.
REQ-026 LENGTH_DATA=62, EN=1, trigger, ticks -> length 2 -> 0 after second length clock, O_WAVEFORM_EN 1 -> 0.
REQ-027 FREQ=1024, SHIFT=1, PERIOD=1, NEGATE=0, trigger -> 1536 after first sweep clock; next calc 2304 > 2047 clears O_WAVEFORM_EN.
REQ-028 FREQ=1500, SHIFT=1, trigger -> immediate overflow 2250, O_WAVEFORM_EN stays 0.
REQ-029 I_TRIGGER and I_FRAME_TICK same cycle on step 7 -> O_VOLUME = I_ENV_INIT, step counter reads 0 next.
REQ-030 I_RESET_N pulsed low mid-sweep -> all outputs 0 asynchronously; no output change until next trigger.

Source files
------------

// File: rtl/sound_ch1_control.sv
// rtl/sound_ch1_control.sv - square channel 1 control: length, sweep, envelope, trigger
//
// Drives the square-wave generator's frequency, duty, volume and enable
// from register-style controls and the 512 Hz frame-sequencer strobe.
//
// Ports:
//   I_BITCLK         clock, all state on rising edge
//   I_RESET_N        asynchronous active-low reset (deassertion synchronised)
//   I_FRAME_TICK     one-cycle frame-sequencer step strobe
//   I_TRIGGER        one-cycle channel (re)start strobe
//   I_FREQ_WR        strobe, loads O_FREQUENCY from I_FREQUENCY
//   I_FREQUENCY      11-bit raw period code
//   I_LENGTH_WR      strobe, loads length counter with 64 - I_LENGTH_DATA
//   I_LENGTH_DATA    6-bit length value
//   I_LENGTH_EN      enables length counting
//   I_SWEEP_PERIOD   sweep timer period (0 acts as 8, disables calculation)
//   I_SWEEP_NEGATE   sweep direction, 1 = subtract
//   I_SWEEP_SHIFT    sweep shift amount
//   I_ENV_INIT       initial volume loaded on trigger
//   I_ENV_UP         envelope direction, 1 = increase
//   I_ENV_PERIOD     envelope period (0 freezes volume)
//   I_DUTY           duty select
//   O_FREQUENCY      registered period code to generator
//   O_DUTY_CYCLE     registered duty to generator
//   O_VOLUME         registered volume to generator
//   O_WAVEFORM_EN    registered channel enable to generator

module sound_ch1_control (
  input  logic        I_BITCLK,
  input  logic        I_RESET_N,
  input  logic        I_FRAME_TICK,
  input  logic        I_TRIGGER,
  input  logic        I_FREQ_WR,
  input  logic [10:0] I_FREQUENCY,
  input  logic        I_LENGTH_WR,
  input  logic [5:0]  I_LENGTH_DATA,
  input  logic        I_LENGTH_EN,
  input  logic [2:0]  I_SWEEP_PERIOD,
  input  logic        I_SWEEP_NEGATE,
  input  logic [2:0]  I_SWEEP_SHIFT,
  input  logic [3:0]  I_ENV_INIT,
  input  logic        I_ENV_UP,
  input  logic [2:0]  I_ENV_PERIOD,
  input  logic [1:0]  I_DUTY,
  output logic [10:0] O_FREQUENCY,
  output logic [1:0]  O_DUTY_CYCLE,
  output logic [3:0]  O_VOLUME,
  output logic        O_WAVEFORM_EN
);

  // Reset asserts immediately, releases two edges later so no flop sees a
  // deassertion racing the clock.
  logic rst_meta;
  logic rst_sync;

  always_ff @(posedge I_BITCLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      rst_meta <= 1'b0;
      rst_sync <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_sync <= rst_meta;
    end
  end

  logic [2:0]  step_cnt;
  logic [6:0]  len_cnt;
  logic [2:0]  sweep_timer;
  logic [10:0] shadow;
  logic        sweep_en;
  logic        channel_on;
  logic [2:0]  env_timer;

  function automatic logic [11:0] sweep_sum(input logic [10:0] base,
                                            input logic [2:0] shift,
                                            input logic neg);
    logic [11:0] delta;
    delta = {1'b0, base} >> shift;
    return neg ? ({1'b0, base} - delta) : ({1'b0, base} + delta);
  endfunction

  logic        dac_on;
  logic        frame_act;
  logic        len_clk;
  logic        sweep_clk;
  logic        env_clk;
  logic [6:0]  len_base;
  logic [6:0]  len_next;
  logic        len_expire;
  logic [2:0]  sweep_dec;
  logic        sweep_fire;
  logic        sweep_calc;
  logic [11:0] sweep_new;
  logic        sweep_ovf;
  logic        sweep_wb;
  logic [11:0] trig_new;
  logic        trig_ovf;
  logic [2:0]  env_dec;

  always_comb begin
    dac_on    = (I_ENV_INIT != 4'd0) | I_ENV_UP;
    // A trigger swallows the actions of a coincident frame tick.
    frame_act = I_FRAME_TICK & ~I_TRIGGER;
    len_clk   = frame_act & ~step_cnt[0];
    sweep_clk = frame_act & (step_cnt[1:0] == 2'b10);
    env_clk   = frame_act & (step_cnt == 3'd7);

    // Length write lands before the trigger's zero-to-64 rule.
    len_base   = I_LENGTH_WR ? (7'd64 - {1'b0, I_LENGTH_DATA}) : len_cnt;
    len_next   = len_base;
    len_expire = 1'b0;
    if (I_TRIGGER) begin
      if (len_base == 7'd0) len_next = 7'd64;
    end else if (!I_LENGTH_WR && len_clk && I_LENGTH_EN && len_cnt != 7'd0) begin
      len_next   = len_cnt - 7'd1;
      len_expire = (len_cnt == 7'd1);
    end

    // Timer wraps 0 -> 7, so a reloaded 0 behaves as period 8.
    sweep_dec  = sweep_timer - 3'd1;
    sweep_fire = sweep_clk & channel_on & (sweep_dec == 3'd0);
    sweep_calc = sweep_fire & sweep_en & (I_SWEEP_PERIOD != 3'd0);
    sweep_new  = sweep_sum(shadow, I_SWEEP_SHIFT, I_SWEEP_NEGATE);
    sweep_ovf  = sweep_calc & sweep_new[11];
    sweep_wb   = sweep_calc & ~sweep_new[11] & (I_SWEEP_SHIFT != 3'd0);

    trig_new = sweep_sum(I_FREQUENCY, I_SWEEP_SHIFT, I_SWEEP_NEGATE);
    trig_ovf = (I_SWEEP_SHIFT != 3'd0) & trig_new[11];

    env_dec = env_timer - 3'd1;
  end

  always_ff @(posedge I_BITCLK or negedge rst_sync) begin
    if (!rst_sync) begin
      step_cnt     <= 3'd0;
      len_cnt      <= 7'd0;
      O_DUTY_CYCLE <= 2'd0;
    end else begin
      step_cnt     <= step_cnt + {2'b00, I_FRAME_TICK};
      len_cnt      <= len_next;
      O_DUTY_CYCLE <= I_DUTY;
    end
  end

  always_ff @(posedge I_BITCLK or negedge rst_sync) begin
    if (!rst_sync) begin
      channel_on  <= 1'b0;
      shadow      <= 11'd0;
      O_FREQUENCY <= 11'd0;
      sweep_timer <= 3'd0;
      sweep_en    <= 1'b0;
      O_VOLUME    <= 4'd0;
      env_timer   <= 3'd0;
    end else if (I_TRIGGER) begin
      channel_on  <= dac_on & ~trig_ovf;
      shadow      <= I_FREQUENCY;
      O_FREQUENCY <= I_FREQUENCY;
      sweep_timer <= I_SWEEP_PERIOD;
      sweep_en    <= (I_SWEEP_PERIOD != 3'd0) | (I_SWEEP_SHIFT != 3'd0);
      O_VOLUME    <= I_ENV_INIT;
      env_timer   <= I_ENV_PERIOD;
    end else begin
      channel_on <= channel_on & dac_on & ~len_expire & ~sweep_ovf;

      if (sweep_clk && channel_on)
        sweep_timer <= sweep_fire ? I_SWEEP_PERIOD : sweep_dec;

      if (sweep_wb) begin
        shadow      <= sweep_new[10:0];
        O_FREQUENCY <= sweep_new[10:0];
      end else if (I_FREQ_WR) begin
        O_FREQUENCY <= I_FREQUENCY;
      end

      if (env_clk && channel_on && I_ENV_PERIOD != 3'd0) begin
        if (env_dec == 3'd0) begin
          env_timer <= I_ENV_PERIOD;
          if (I_ENV_UP && O_VOLUME != 4'd15)
            O_VOLUME <= O_VOLUME + 4'd1;
          else if (!I_ENV_UP && O_VOLUME != 4'd0)
            O_VOLUME <= O_VOLUME - 4'd1;
        end else begin
          env_timer <= env_dec;
        end
      end
    end
  end

  assign O_WAVEFORM_EN = channel_on;

endmodule

// File: tb/tb_sound_ch1_control.sv
// tb/tb_sound_ch1_control.sv - directed self-checking bench for sound_ch1_control

module tb_sound_ch1_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        trigger = 1'b0;
  logic        freq_wr = 1'b0;
  logic [10:0] frequency = 11'd0;
  logic        length_wr = 1'b0;
  logic [5:0]  length_data = 6'd0;
  logic        length_en = 1'b0;
  logic [2:0]  sweep_period = 3'd0;
  logic        sweep_negate = 1'b0;
  logic [2:0]  sweep_shift = 3'd0;
  logic [3:0]  env_init = 4'd0;
  logic        env_up = 1'b0;
  logic [2:0]  env_period = 3'd0;
  logic [1:0]  duty = 2'd0;
  logic [10:0] o_freq;
  logic [1:0]  o_duty;
  logic [3:0]  o_vol;
  logic        o_en;

  int total = 0;
  int bad = 0;

  sound_ch1_control dut (
    .I_BITCLK      (clk),
    .I_RESET_N     (rst_n),
    .I_FRAME_TICK  (frame_tick),
    .I_TRIGGER     (trigger),
    .I_FREQ_WR     (freq_wr),
    .I_FREQUENCY   (frequency),
    .I_LENGTH_WR   (length_wr),
    .I_LENGTH_DATA (length_data),
    .I_LENGTH_EN   (length_en),
    .I_SWEEP_PERIOD(sweep_period),
    .I_SWEEP_NEGATE(sweep_negate),
    .I_SWEEP_SHIFT (sweep_shift),
    .I_ENV_INIT    (env_init),
    .I_ENV_UP      (env_up),
    .I_ENV_PERIOD  (env_period),
    .I_DUTY        (duty),
    .O_FREQUENCY   (o_freq),
    .O_DUTY_CYCLE  (o_duty),
    .O_VOLUME      (o_vol),
    .O_WAVEFORM_EN (o_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick(input logic trig);
    frame_tick = 1'b1;
    trigger = trig;
    cyc();
    frame_tick = 1'b0;
    trigger = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  task automatic trig_only();
    trigger = 1'b1;
    cyc();
    trigger = 1'b0;
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    check("rst_freq", o_freq, 0);
    check("rst_duty", o_duty, 0);
    check("rst_vol", o_vol, 0);
    check("rst_en", o_en, 0);
    check("rst_step", dut.step_cnt, 0);

    // Duty passes through with one cycle latency
    duty = 2'd2;
    cyc();
    check("duty", o_duty, 2);
    duty = 2'd0;
    cyc();

    // Envelope down from 10, trigger coincident with step-7 tick
    env_init = 4'd10; env_up = 1'b0; env_period = 3'd1;
    ticks(7);
    check("pre_trig_step", dut.step_cnt, 7);
    tick(1'b1);
    check("trig_tick_vol", o_vol, 10);
    check("trig_tick_step", dut.step_cnt, 0);
    check("trig_tick_en", o_en, 1);
    ticks(8);
    check("env_vol_9", o_vol, 9);
    ticks(8);
    check("env_vol_8", o_vol, 8);
    ticks(80);
    check("env_sat_0", o_vol, 0);
    check("env_sat_en", o_en, 1);

    // Length 62 -> counter 2, write and trigger same cycle (step 0 now)
    env_init = 4'd15; env_period = 3'd0;
    length_data = 6'd62; length_en = 1'b1;
    length_wr = 1'b1; trigger = 1'b1;
    cyc();
    length_wr = 1'b0; trigger = 1'b0;
    check("len_load", dut.len_cnt, 2);
    check("len_en0", o_en, 1);
    tick(1'b0);
    check("len_first", o_en, 1);
    tick(1'b0);
    tick(1'b0);
    check("len_expired", o_en, 0);
    check("len_zero", dut.len_cnt, 0);
    length_en = 1'b0;
    trig_only();
    check("len_reload64", dut.len_cnt, 64);
    check("len_retrig_en", o_en, 1);

    // Immediate overflow on trigger; envelope holds while channel off (step 3)
    frequency = 11'd1500; sweep_shift = 3'd1; sweep_period = 3'd0;
    env_init = 4'd5; env_period = 3'd1;
    trig_only();
    check("ovf_en", o_en, 0);
    check("ovf_freq", o_freq, 1500);
    check("ovf_vol", o_vol, 5);
    ticks(8);
    check("off_vol_hold", o_vol, 5);

    // Sweep up 1024 -> 1536 -> overflow; advance to step 0 first
    ticks(5);
    frequency = 11'd1024; sweep_shift = 3'd1; sweep_period = 3'd1; sweep_negate = 1'b0;
    env_init = 4'd15; env_period = 3'd0;
    trig_only();
    check("sw_trig_en", o_en, 1);
    check("sw_trig_freq", o_freq, 1024);
    ticks(2);
    freq_wr = 1'b1; frequency = 11'd5;
    tick(1'b0);
    freq_wr = 1'b0;
    check("sw_first", o_freq, 1536);
    freq_wr = 1'b1; frequency = 11'd100;
    cyc();
    freq_wr = 1'b0;
    check("freq_wr", o_freq, 100);
    ticks(3);
    check("sw_pre_ovf_en", o_en, 1);
    tick(1'b0);
    check("sw_ovf_en", o_en, 0);
    check("sw_ovf_freq", o_freq, 100);

    // Negate sweep, then asynchronous reset mid-sweep (step 7 -> 0)
    tick(1'b0);
    frequency = 11'd1024; sweep_negate = 1'b1;
    trig_only();
    ticks(3);
    check("neg_freq", o_freq, 512);
    check("neg_en", o_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_freq", o_freq, 0);
    check("async_en", o_en, 0);
    check("async_vol", o_vol, 0);
    check("async_duty", o_duty, 0);
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    ticks(16);
    check("post_rst_en", o_en, 0);
    check("post_rst_freq", o_freq, 0);
    check("post_rst_vol", o_vol, 0);
    trig_only();
    check("retrig_en", o_en, 1);
    check("retrig_freq", o_freq, 1024);
    check("retrig_vol", o_vol, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
